// File: rtl/mac_mul_mid_if.sv
// -----------------------------------------------------------------------------
// mac_mul_mid_pkg / mac_op_if / mac_prod_if
//
// Purpose:
//   Shared datatype encoding for the MAC mid-path plus the two valid/ready
//   stream interfaces used by the operand multiplier:
//     mac_op_if   - decoded operand beat (activation A, weight B, datatype)
//     mac_prod_if - un-normalised product beat (sign, exponent sum, mantissa)
//
// Modports:
//   master - drives valid and payload, samples ready
//   slave  - samples valid and payload, drives ready
// -----------------------------------------------------------------------------
package mac_mul_mid_pkg;

    // Per-beat arithmetic mode. FP8 is the reset/idle encoding.
    typedef enum logic {
        MAC_DATATYPE_FP8 = 1'b0,
        MAC_DATATYPE_INT = 1'b1
    } mac_datatype;

endpackage

interface mac_op_if;
    import mac_mul_mid_pkg::*;

    logic        valid;
    logic        ready;
    mac_datatype datatype;
    logic        a_iszero;
    logic        b_iszero;
    logic        a_sign;
    logic        b_sign;
    logic [3:0]  a_exp;
    logic [3:0]  b_exp;
    logic [8:0]  a_mant;
    logic [8:0]  b_mant;

    modport master (
        output valid, datatype,
        output a_iszero, b_iszero, a_sign, b_sign,
        output a_exp, b_exp, a_mant, b_mant,
        input  ready
    );

    modport slave (
        input  valid, datatype,
        input  a_iszero, b_iszero, a_sign, b_sign,
        input  a_exp, b_exp, a_mant, b_mant,
        output ready
    );
endinterface

interface mac_prod_if;
    import mac_mul_mid_pkg::*;

    logic        valid;
    logic        ready;
    mac_datatype datatype;
    logic        iszero;
    logic        sign;
    logic [5:0]  exp;
    logic [17:0] mant;

    modport master (
        output valid, datatype, iszero, sign, exp, mant,
        input  ready
    );

    modport slave (
        input  valid, datatype, iszero, sign, exp, mant,
        output ready
    );
endinterface

// File: rtl/mac_mul_mid.sv
// -----------------------------------------------------------------------------
// mac_mul_mid
//
// Purpose:
//   Two-stage pipelined operand multiplier sitting directly after the MAC
//   mid-path decoder. Each beat carries two decoded operands and a datatype;
//   the block emits an un-normalised product for the aligner/accumulator.
//     S1 : registers the raw operands and datatype
//     S2 : output registers holding the computed product
//   Full valid/ready backpressure, 1 beat/cycle, 2-cycle latency unstalled.
//
// Ports:
//   i_clk       clock
//   i_rst       synchronous reset, active-high
//   op          operand stream (slave): valid/ready, datatype, A/B fields
//   prod        product stream (master): valid/ready, datatype, iszero,
//               sign, exp[5:0], mant[17:0]
//   i_cnt_clr   synchronous clear of the zero-product counter
//   o_zero_cnt  saturating count of zero products transferred downstream
//
// Parameters:
//   CNT_W        width of the zero-product counter
//   FP8_EXP_MIN  effective exponent used for FP8 operands with exp == 0
// -----------------------------------------------------------------------------
module mac_mul_mid
    import mac_mul_mid_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int FP8_EXP_MIN = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mac_op_if.slave          op,
    mac_prod_if.master       prod,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_zero_cnt
);

    localparam logic [3:0] EXP_MIN = 4'(FP8_EXP_MIN);

    // -------------------------------------------------------------------------
    // Stage 1 registers
    // -------------------------------------------------------------------------
    logic        s1_valid;
    mac_datatype s1_datatype;
    logic        s1_a_iszero;
    logic        s1_b_iszero;
    logic        s1_a_sign;
    logic        s1_b_sign;
    logic [3:0]  s1_a_exp;
    logic [3:0]  s1_b_exp;
    logic [8:0]  s1_a_mant;
    logic [8:0]  s1_b_mant;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic s2_adv;
    logic in_xfer;
    logic out_xfer;

    // The output stage can take a new beat when it is empty or being drained.
    assign s2_adv   = !prod.valid || prod.ready;
    // Combinational from downstream ready so a full pipe keeps streaming
    // without a bubble when input and output transfer in the same cycle.
    assign op.ready = !s1_valid || s2_adv;
    assign in_xfer  = op.valid && op.ready;
    assign out_xfer = prod.valid && prod.ready;

    // -------------------------------------------------------------------------
    // Arithmetic between S1 and S2
    // -------------------------------------------------------------------------
    logic [3:0]         eff_a_exp;
    logic [3:0]         eff_b_exp;
    logic [7:0]         fp_mant;
    logic signed [17:0] int_mant;

    logic        nx_iszero;
    logic        nx_sign;
    logic [5:0]  nx_exp;
    logic [17:0] nx_mant;

    // FP8 zero/subnormal exponents behave as the minimum normal exponent.
    assign eff_a_exp = (s1_a_exp == 4'd0) ? EXP_MIN : s1_a_exp;
    assign eff_b_exp = (s1_b_exp == 4'd0) ? EXP_MIN : s1_b_exp;

    // FP8 uses only the low 4 mantissa bits (hidden bit + 3 fraction bits).
    assign fp_mant  = {4'd0, s1_a_mant[3:0]} * {4'd0, s1_b_mant[3:0]};

    // Integer mode: both 9-bit mantissas are two's complement.
    assign int_mant = 18'($signed(s1_a_mant)) * 18'($signed(s1_b_mant));

    // NOTE: every output of a combinational block is given a default first,
    // so no path through the if/else can leave it unassigned (no latch).
    always_comb begin
        nx_iszero = s1_a_iszero || s1_b_iszero;
        nx_sign   = 1'b0;
        nx_exp    = 6'd0;
        nx_mant   = 18'd0;

        if (!nx_iszero) begin
            if (s1_datatype == MAC_DATATYPE_FP8) begin
                nx_sign = s1_a_sign ^ s1_b_sign;
                nx_exp  = {2'b00, eff_a_exp} + {2'b00, eff_b_exp};
                nx_mant = {10'd0, fp_mant};
            end else begin
                // Sign and exponent inputs are meaningless for integers; the
                // product's own sign bit is reported instead.
                nx_mant = int_mant;
                nx_sign = int_mant[17];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline registers and zero counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid      <= 1'b0;
            prod.valid    <= 1'b0;
            prod.datatype <= MAC_DATATYPE_FP8;
            prod.iszero   <= 1'b0;
            prod.sign     <= 1'b0;
            prod.exp      <= 6'd0;
            prod.mant     <= 18'd0;
            o_zero_cnt    <= '0;
        end else begin
            // Stage 1: load on accept, empty when drained with nothing new.
            // NOTE: the S1 payload is deliberately not reset; it is only ever
            // consumed while s1_valid is set, so reset only the valid bit.
            if (in_xfer) begin
                s1_valid    <= 1'b1;
                s1_datatype <= op.datatype;
                s1_a_iszero <= op.a_iszero;
                s1_b_iszero <= op.b_iszero;
                s1_a_sign   <= op.a_sign;
                s1_b_sign   <= op.b_sign;
                s1_a_exp    <= op.a_exp;
                s1_b_exp    <= op.b_exp;
                s1_a_mant   <= op.a_mant;
                s1_b_mant   <= op.b_mant;
            end else if (s1_valid && s2_adv) begin
                s1_valid <= 1'b0;
            end

            // Stage 2: payload only changes when a real beat moves in, so it
            // holds under stall and keeps its last value while idle.
            if (s2_adv) begin
                prod.valid <= s1_valid;
                if (s1_valid) begin
                    prod.datatype <= s1_datatype;
                    prod.iszero   <= nx_iszero;
                    prod.sign     <= nx_sign;
                    prod.exp      <= nx_exp;
                    prod.mant     <= nx_mant;
                end
            end

            // Clear wins over a same-cycle increment; saturate at all-ones.
            if (i_cnt_clr) begin
                o_zero_cnt <= '0;
            end else if (out_xfer && prod.iszero && (o_zero_cnt != '1)) begin
                o_zero_cnt <= o_zero_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_mul_mid.sv
// -----------------------------------------------------------------------------
// tb_mac_mul_mid
//
// Self-checking bench for mac_mul_mid. A behavioural model turns every
// accepted operand beat into an expected product (plain integer arithmetic)
// and queues it; one compare process pops and checks on every output
// transfer, checks stall stability and tracks the zero counter. Directed
// sections pin the model with hand-computed values; a random phase mixes
// datatypes, zero flags and backpressure. A second instance with a 4-bit
// counter exercises saturation.
// -----------------------------------------------------------------------------
module tb_mac_mul_mid;
    import mac_mul_mid_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnt_clr = 1'b0;
    logic        sat_clr = 1'b0;
    logic [15:0] zero_cnt;
    logic [3:0]  sat_cnt;

    int vectors     = 0;
    int miscompares = 0;

    mac_op_if   op_if ();
    mac_prod_if prod_if ();
    mac_op_if   sat_op ();
    mac_prod_if sat_prod ();

    always #5 clk = ~clk;

    mac_mul_mid #(.CNT_W(16), .FP8_EXP_MIN(1)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .op         (op_if),
        .prod       (prod_if),
        .i_cnt_clr  (cnt_clr),
        .o_zero_cnt (zero_cnt)
    );

    mac_mul_mid #(.CNT_W(4), .FP8_EXP_MIN(1)) dut_sat (
        .i_clk      (clk),
        .i_rst      (rst),
        .op         (sat_op),
        .prod       (sat_prod),
        .i_cnt_clr  (sat_clr),
        .o_zero_cnt (sat_cnt)
    );

    typedef struct packed {
        logic       dt;
        logic       az, bz, as, bs;
        logic [3:0] ae, be;
        logic [8:0] am, bm;
    } beat_t;

    typedef struct packed {
        logic        dt;
        logic        iszero;
        logic        sign;
        logic [5:0]  exp;
        logic [17:0] mant;
    } prod_t;

    localparam logic DT_FP8 = 1'b0;
    localparam logic DT_INT = 1'b1;

    prod_t exp_q[$];
    logic [15:0] model_cnt = '0;
    logic  hold_pending = 1'b0;
    prod_t hold_snap;
    logic  rand_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic record_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Product rules in plain arithmetic.
    function automatic prod_t model(input beat_t b);
        prod_t p;
        int ea, eb, av, bv, ip;
        p    = '0;
        p.dt = b.dt;
        if (b.az || b.bz) begin
            p.iszero = 1'b1;
            return p;
        end
        if (b.dt == DT_FP8) begin
            ea     = (b.ae == 0) ? 1 : int'(b.ae);
            eb     = (b.be == 0) ? 1 : int'(b.be);
            p.sign = b.as ^ b.bs;
            p.exp  = 6'(ea + eb);
            p.mant = 18'((int'(b.am) % 16) * (int'(b.bm) % 16));
        end else begin
            av = int'(b.am);
            bv = int'(b.bm);
            if (av >= 256) av -= 512;
            if (bv >= 256) bv -= 512;
            ip     = av * bv;
            p.mant = 18'(ip);
            p.sign = (ip < 0);
        end
        return p;
    endfunction

    function automatic beat_t mk(input logic dt, input logic az, input logic bz,
                                 input logic as, input logic bs,
                                 input logic [3:0] ae, input logic [3:0] be,
                                 input logic [8:0] am, input logic [8:0] bm);
        beat_t b;
        b.dt = dt; b.az = az; b.bz = bz; b.as = as; b.bs = bs;
        b.ae = ae; b.be = be; b.am = am; b.bm = bm;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.dt = 1'($urandom_range(1));
        b.az = ($urandom_range(7) == 0);
        b.bz = ($urandom_range(7) == 0);
        b.as = 1'($urandom_range(1));
        b.bs = 1'($urandom_range(1));
        b.ae = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
        b.be = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
        b.am = ($urandom_range(9) == 0) ? 9'h100 : 9'($urandom_range(511));
        b.bm = 9'($urandom_range(511));
        return b;
    endfunction

    task automatic apply(input beat_t b);
        op_if.datatype = mac_datatype'(b.dt);
        op_if.a_iszero = b.az;
        op_if.b_iszero = b.bz;
        op_if.a_sign   = b.as;
        op_if.b_sign   = b.bs;
        op_if.a_exp    = b.ae;
        op_if.b_exp    = b.be;
        op_if.a_mant   = b.am;
        op_if.b_mant   = b.bm;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input beat_t b);
        int n;
        apply(b);
        op_if.valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (op_if.ready) break;
        end
        if (n == 50) record_fail("accept_timeout");
        @(posedge clk);
        #1 op_if.valid = 1'b0;
    endtask

    // Number of cycles from the accept cycle until o_valid is seen (0 = never).
    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (prod_if.valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drained_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Single compare process: products, stall stability, zero counter.
    always @(negedge clk) begin
        prod_t got;
        prod_t e;
        got = {logic'(prod_if.datatype), prod_if.iszero, prod_if.sign,
               prod_if.exp, prod_if.mant};
        if (rst) begin
            exp_q.delete();
            model_cnt    = '0;
            hold_pending = 1'b0;
        end else begin
            check("zero_cnt", zero_cnt, model_cnt);
            if (hold_pending) check("hold_stable", got, hold_snap);
            hold_pending = prod_if.valid && !prod_if.ready;
            hold_snap    = got;

            if (prod_if.valid && prod_if.ready) begin
                if (exp_q.size() == 0) begin
                    record_fail("unexpected_output_beat");
                end else begin
                    e = exp_q.pop_front();
                    check("product", got, e);
                    if (e.iszero && !cnt_clr && model_cnt != 16'hFFFF) model_cnt++;
                end
            end
            if (cnt_clr) model_cnt = '0;

            if (op_if.valid && op_if.ready)
                exp_q.push_back(model(mk(logic'(op_if.datatype), op_if.a_iszero,
                    op_if.b_iszero, op_if.a_sign, op_if.b_sign, op_if.a_exp,
                    op_if.b_exp, op_if.a_mant, op_if.b_mant)));
        end
    end

    // Random backpressure and counter clears during the random phase.
    always @(posedge clk) begin
        if (rand_on) begin
            #1;
            prod_if.ready = ($urandom_range(3) != 0);
            cnt_clr       = ($urandom_range(40) == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b, z;
        beat_t s[4];
        int lat, idx;

        op_if.valid   = 1'b0;
        apply('0);
        prod_if.ready = 1'b1;

        sat_op.valid    = 1'b0;
        sat_op.datatype = MAC_DATATYPE_FP8;
        sat_op.a_iszero = 1'b1;
        sat_op.b_iszero = 1'b0;
        sat_op.a_sign   = 1'b0;
        sat_op.b_sign   = 1'b0;
        sat_op.a_exp    = 4'd0;
        sat_op.b_exp    = 4'd0;
        sat_op.a_mant   = 9'd0;
        sat_op.b_mant   = 9'd0;
        sat_prod.ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_o_valid",  prod_if.valid, 0);
        check("rst_o_ready",  op_if.ready, 1);
        check("rst_datatype", prod_if.datatype, MAC_DATATYPE_FP8);
        check("rst_iszero",   prod_if.iszero, 0);
        check("rst_sign",     prod_if.sign, 0);
        check("rst_exp",      prod_if.exp, 0);
        check("rst_mant",     prod_if.mant, 0);
        check("rst_zero_cnt", zero_cnt, 0);
        check("rst_sat_cnt",  sat_cnt, 0);
        @(posedge clk);
        #1;

        // FP8 1.0 x 1.0
        send_beat(mk(DT_FP8, 0, 0, 0, 0, 4'd7, 4'd7, 9'h008, 9'h008));
        wait_out(lat);
        check("fp8_one_latency", lat, 2);
        check("fp8_one_sign",    prod_if.sign, 0);
        check("fp8_one_exp",     prod_if.exp, 14);
        check("fp8_one_mant",    prod_if.mant, 64);
        check("fp8_one_iszero",  prod_if.iszero, 0);
        @(posedge clk);
        #1;

        // FP8 subnormal A, negative A
        send_beat(mk(DT_FP8, 0, 0, 1, 0, 4'd0, 4'd7, 9'h001, 9'h008));
        wait_out(lat);
        check("fp8_sub_latency", lat, 2);
        check("fp8_sub_sign",    prod_if.sign, 1);
        check("fp8_sub_exp",     prod_if.exp, 8);
        check("fp8_sub_mant",    prod_if.mant, 8);
        @(posedge clk);
        #1;

        // Integer -1 x 127, exp/sign inputs deliberately non-zero
        send_beat(mk(DT_INT, 0, 0, 0, 1, 4'd5, 4'd9, 9'h1FF, 9'h07F));
        wait_out(lat);
        check("int_latency",  lat, 2);
        check("int_mant",     prod_if.mant, 18'h3FF81);
        check("int_sign",     prod_if.sign, 1);
        check("int_exp",      prod_if.exp, 0);
        check("int_datatype", prod_if.datatype, MAC_DATATYPE_INT);
        @(posedge clk);
        #1;

        // Four-beat stream under a 3-cycle downstream stall
        s[0] = mk(DT_FP8, 0, 0, 0, 0, 4'd1, 4'd2, 9'h009, 9'h00A);
        s[1] = mk(DT_INT, 0, 0, 0, 0, 4'd0, 4'd0, 9'h0FF, 9'h101);
        s[2] = mk(DT_FP8, 0, 0, 1, 1, 4'd15, 4'd15, 9'h00F, 9'h00F);
        s[3] = mk(DT_INT, 0, 0, 0, 0, 4'd0, 4'd0, 9'h100, 9'h100);
        prod_if.ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
            if (cyc == 5) prod_if.ready = 1'b1;
            apply(s[idx]);
            op_if.valid = 1'b1;
            @(negedge clk);
            if (cyc == 2) begin
                check("stall_queued_beats", idx, 2);
                check("stall_o_ready",      op_if.ready, 0);
            end
            if (cyc == 4) check("stall_o_valid", prod_if.valid, 1);
            if (op_if.ready) idx++;
            @(posedge clk);
            #1;
        end
        op_if.valid = 1'b0;
        check("stall_all_accepted", idx, 4);
        drain();

        // Zero beats: A flagged zero, other fields deliberately non-zero
        z = mk(DT_FP8, 1, 0, 1, 0, 4'd9, 4'd7, 9'h1F3, 9'h008);
        for (int k = 0; k < 3; k++) begin
            send_beat(z);
            wait_out(lat);
            check("zero_iszero", prod_if.iszero, 1);
            check("zero_sign",   prod_if.sign, 0);
            check("zero_exp",    prod_if.exp, 0);
            check("zero_mant",   prod_if.mant, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("zero_cnt_three", zero_cnt, 3);
        @(posedge clk);
        #1;

        // Clear in the same cycle as a zero transfer
        prod_if.ready = 1'b0;
        send_beat(z);
        wait_out(lat);
        check("clr_pre_cnt", zero_cnt, 3);
        @(posedge clk);
        #1;
        prod_if.ready = 1'b1;
        cnt_clr       = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_priority", zero_cnt, 0);
        @(posedge clk);
        #1;

        // Reset with both stages full
        send_beat(z);
        wait_out(lat);
        @(posedge clk);
        #1;
        prod_if.ready = 1'b0;
        b = mk(DT_FP8, 0, 0, 0, 0, 4'd3, 4'd4, 9'h00B, 9'h00C);
        send_beat(b);
        send_beat(b);
        @(negedge clk);
        check("full_o_ready",  op_if.ready, 0);
        check("full_o_valid",  prod_if.valid, 1);
        check("full_zero_cnt", zero_cnt, 1);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        prod_if.ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_o_valid",  prod_if.valid, 0);
        check("midrst_o_ready",  op_if.ready, 1);
        check("midrst_zero_cnt", zero_cnt, 0);
        @(negedge clk);
        check("midrst_dropped",  prod_if.valid, 0);
        @(posedge clk);
        #1;

        // Random mixed stream with random backpressure
        rand_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(4) == 0) begin
                @(posedge clk);
                #1;
            end
            send_beat(rand_beat());
        end
        rand_on = 1'b0;
        @(posedge clk);
        #1;
        prod_if.ready = 1'b1;
        cnt_clr       = 1'b0;
        drain();

        // Saturation on the 4-bit counter instance: 20 zero transfers
        sat_op.valid = 1'b1;
        repeat (20) @(posedge clk);
        #1 sat_op.valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sat_cnt_saturated", sat_cnt, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_mul_mid.md
Name: mac_mul_mid

Overview:
- Pipelined operand multiplier directly downstream of the MAC mid-path decoder.
- Consumes two decoded operands (activation A, weight B) plus the beat datatype.
- Produces an un-normalised product (sign, exponent sum, mantissa product) for the downstream aligner/accumulator.
- Provides a valid/ready handshake with full backpressure and a saturating zero-product counter.

Parameters:
- CNT_W, 16, width of the zero-product counter.
- FP8_EXP_MIN, 1, effective exponent substituted for FP8 operands whose decoded exponent is 0 (subnormal/zero).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous reset, active-high
- i_valid  input  1  operand beat valid
- o_ready  output  1  block can accept a beat this cycle
- i_datatype  input  mac_datatype  per-beat type; MAC_DATATYPE_FP8 or integer mode
- i_a_iszero / i_b_iszero  input  1  decoded zero flags
- i_a_sign / i_b_sign  input  1  decoded signs
- i_a_exp / i_b_exp  input  4  decoded exponents
- i_a_mant / i_b_mant  input  9  decoded mantissas
- o_valid  output  1  product beat valid
- i_ready  input  1  downstream accepts the product
- o_datatype  output  mac_datatype  datatype travelling with the beat
- o_iszero  output  1  product is zero
- o_sign  output  1  product sign
- o_exp  output  6  unbiased sum of effective exponents (FP8), 0 in integer mode
- o_mant  output  18  mantissa product
- i_cnt_clr  input  1  synchronous clear of zero counter
- o_zero_cnt  output  CNT_W  count of zero products transferred

Behaviour:
- Reset: all stage valids = 0. o_valid = 0, o_datatype = FP8 encoding, o_iszero = 0, o_sign = 0, o_exp = 0, o_mant = 0, o_zero_cnt = 0. Reset mid-operation drops every in-flight beat; no output transfer occurs in the reset cycle.
- Pipeline has two register stages:
  - S1 registers the raw operands and datatype.
  - S2 (the output registers) holds the computed product.
- Latency: a beat accepted in cycle N appears on o_valid in cycle N+2 when there is no stall. Throughput is 1 beat/cycle.
- Handshake:
  - Input transfer = i_valid && o_ready. Output transfer = o_valid && i_ready.
  - s2_adv = !o_valid || i_ready.
  - o_ready = !s1_valid || s2_adv (combinational from i_ready).
  - S1 moves into S2 when s1_valid && s2_adv. S1 loads on an input transfer.
  - S1 valid clears when S1 moves out and no new beat enters.
  - While o_valid && !i_ready, all o_* data hold stable. When o_valid = 0, data outputs hold their last value.
- Arithmetic, computed between S1 and S2:
  - iszero = a_iszero || b_iszero. When iszero, force sign = 0, exp = 0, mant = 0.
  - FP8 mode:
    - sign = a_sign ^ b_sign.
    - eff_exp = (exp == 0) ? FP8_EXP_MIN : exp.
    - o_exp = eff_a + eff_b, 6-bit, range 2..30, no bias removed.
    - o_mant = a_mant[3:0] * b_mant[3:0], zero-extended to 18 bits. Upper mantissa bits [8:4] are ignored.
  - Integer mode:
    - Mantissas are 9-bit two's complement.
    - o_mant = signed 18-bit product.
    - o_sign = o_mant[17].
    - o_exp = 0.
    - Sign/exp inputs are ignored.
    - iszero forcing still applies.
- Datatype is latched per beat, so mixed-type streams are legal back-to-back.
- Zero counter:
  - Increments by 1 on each output transfer with o_iszero = 1.
  - Saturates at all-ones (no wrap).
  - i_cnt_clr loads 0 and takes priority over a same-cycle increment.
- Simultaneous input and output transfer while full: both occur and the pipeline stays full with no bubble.

Test Plan:
- FP8, A = B = exp 7 mant 9'h008 (1.0), i_ready = 1 → o_valid exactly 2 cycles after accept; o_sign = 0, o_exp = 14, o_mant = 64, o_iszero = 0.
- FP8 subnormal A = exp 0 mant 9'h001, B = exp 7 mant 9'h008, A sign = 1 → o_exp = 8, o_mant = 8, o_sign = 1.
- Integer mode, A mant = 9'h1FF (−1), B mant = 9'h07F (127) → o_mant = 18'h3FF81 (−127), o_sign = 1, o_exp = 0.
- Stream 4 beats with i_ready held low for 3 cycles → o_ready drops after 2 beats are queued; o_* held stable; all 4 beats emerge in order, none lost or duplicated.
- Zero beats:
  - A iszero = 1 with B = 1.0, 3 transfers → o_iszero = 1, data zeroed, o_zero_cnt = 3.
  - Assert i_cnt_clr in the same cycle as a zero transfer → o_zero_cnt = 0.
  - Preload near all-ones → counter saturates at 16'hFFFF.
- Assert i_rst with both stages full → next cycle o_valid = 0, o_ready = 1, o_zero_cnt = 0, and no output transfer in the reset cycle.
